wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 198 +++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2 -- two-master to one-slave Wishbone arbiter with a strobe timeout.
//
// Purpose:
//   Shares one Wishbone slave between two masters. A grant is held until the
//   granted master drops cyc, so a cycle is never pre-empted. Simultaneous
//   requests from IDLE go to the master that was not granted last, which
//   alternates between the masters when both are busy. A slave that stays
//   silent for TIMEOUT strobe cycles gets a one-cycle err to the master. After
//   that, s_stb is held low until the master ends the strobe.
//
// Parameters:
//   ADDR_WIDTH  Wishbone address width
//   TIMEOUT     strobe cycles before a silent slave is errored (0 = never)
//
// Ports:
//   sys_clk, sys_rst              clock and synchronous active-low reset
//   mN_cyc/stb/we/adr/mosi/sel    master N request inputs (N = 0, 1)
//   mN_miso/ack/err               master N response outputs
//   s_cyc/stb/we/adr/mosi/sel     shared slave request outputs
//   s_miso/ack/err                shared slave response inputs
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  // master 0
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_adr,
  input  logic [31:0]           m0_mosi,
  input  logic [3:0]            m0_sel,
  output logic [31:0]           m0_miso,
  output logic                  m0_ack,
  output logic                  m0_err,
  // master 1
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_adr,
  input  logic [31:0]           m1_mosi,
  input  logic [3:0]            m1_sel,
  output logic [31:0]           m1_miso,
  output logic                  m1_ack,
  output logic                  m1_err,
  // shared slave
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_adr,
  output logic [31:0]           s_mosi,
  output logic [3:0]            s_sel,
  input  logic [31:0]           s_miso,
  input  logic                  s_ack,
  input  logic                  s_err
);

  // The counter only has to reach TIMEOUT-1, but it is kept at least 1 bit wide.
  localparam int CW_RAW    = $clog2(TIMEOUT + 1);
  localparam int CW        = (TIMEOUT > 0 && CW_RAW > 1) ? CW_RAW : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
  localparam logic          TO_EN   = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            to_flag_q, to_flag_d;

  // Master inputs gathered into arrays so the output mux can index by grant.
  logic [1:0]            m_cyc, m_stb, m_we;
  logic [ADDR_WIDTH-1:0] m_adr  [2];
  logic [31:0]           m_mosi [2];
  logic [3:0]            m_sel  [2];

  assign m_cyc     = {m1_cyc, m0_cyc};
  assign m_stb     = {m1_stb, m0_stb};
  assign m_we      = {m1_we,  m0_we};
  assign m_adr[0]  = m0_adr;
  assign m_adr[1]  = m1_adr;
  assign m_mosi[0] = m0_mosi;
  assign m_mosi[1] = m1_mosi;
  assign m_sel[0]  = m0_sel;
  assign m_sel[1]  = m1_sel;

  // Gating with sys_rst keeps every output quiet while reset is held. This also
  // suppresses any ack or err from a cycle that the reset aborts.
  logic [1:0] gnt;
  logic       gidx;
  logic       active;

  assign gnt[0] = sys_rst & (state_q == GRANT0);
  assign gnt[1] = sys_rst & (state_q == GRANT1);
  assign gidx   = (state_q == GRANT1);
  assign active = |gnt;

  // Slave-side request mux.
  always_comb begin
    s_cyc  = 1'b0;
    s_stb  = 1'b0;
    s_we   = 1'b0;
    s_adr  = '0;
    s_mosi = '0;
    s_sel  = '0;
    if (active) begin
      s_cyc  = m_cyc[gidx];
      s_stb  = m_stb[gidx] & ~to_flag_q;
      s_we   = m_we[gidx];
      s_adr  = m_adr[gidx];
      s_mosi = m_mosi[gidx];
      s_sel  = m_sel[gidx];
    end
  end

  // A strobe cycle the slave has not answered. A response in the final cycle
  // clears this, so the slave wins that tie against the timeout.
  logic wait_cond;
  logic to_fire;

  assign wait_cond = s_cyc & s_stb & ~s_ack & ~s_err;
  assign to_fire   = TO_EN & wait_cond & (cnt_q == TO_LAST);

  // Master-side response demux.
  logic [31:0] m_miso_w [2];
  logic [1:0]  m_ack_w, m_err_w;

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign m_miso_w[gi] = gnt[gi] ? s_miso : 32'd0;
    assign m_ack_w[gi]  = gnt[gi] & s_ack;
    assign m_err_w[gi]  = gnt[gi] & (s_err | to_fire);
  end

  assign m0_miso = m_miso_w[0];
  assign m0_ack  = m_ack_w[0];
  assign m0_err  = m_err_w[0];
  assign m1_miso = m_miso_w[1];
  assign m1_ack  = m_ack_w[1];
  assign m1_err  = m_err_w[1];

  // Next-state logic.
  logic state_chg;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_d = last_grant_q ? GRANT0 : GRANT1;
        else if (m0_cyc)      state_d = GRANT0;
        else if (m1_cyc)      state_d = GRANT1;
      end
      GRANT0: if (!m0_cyc) state_d = m1_cyc ? GRANT1 : IDLE;
      GRANT1: if (!m1_cyc) state_d = m0_cyc ? GRANT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == GRANT0 && state_q != GRANT0) last_grant_d = 1'b0;
    if (state_d == GRANT1 && state_q != GRANT1) last_grant_d = 1'b1;
  end

  assign state_chg = (state_d != state_q);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_chg || !wait_cond || to_fire || !TO_EN) cnt_d = '0;

    to_flag_d = to_flag_q;
    if (state_chg)
      to_flag_d = 1'b0;
    else if (to_fire)
      to_flag_d = 1'b1;
    else if (to_flag_q && !(m_cyc[gidx] && m_stb[gidx]))
      to_flag_d = 1'b0;  // the master has ended the strobe it was erroring
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;  // m0 wins the first tie
      cnt_q        <= '0;
      to_flag_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      to_flag_q    <= to_flag_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter2 -- directed self-checking bench for wb_arbiter2.
//
// Two instances share the stimulus. dut has TIMEOUT=4 and dut0 has TIMEOUT=0,
// so dut0 shows what happens when the timeout is disabled. Inputs change #1
// after each rising edge, and outputs are checked a further #1 later.
// -----------------------------------------------------------------------------
module tb_wb_arbiter2;

  localparam int AW = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [31:0]   m0_mosi, m1_mosi;
  logic [3:0]    m0_sel, m1_sel;
  logic [31:0]   s_miso;
  logic          s_ack, s_err;

  // outputs of the TIMEOUT=4 instance
  logic [31:0]   m0_miso, m1_miso, s_mosi;
  logic          m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [3:0]    s_sel;

  // outputs of the TIMEOUT=0 instance
  logic [31:0]   z_m0_miso, z_m1_miso, z_s_mosi;
  logic          z_m0_ack, z_m0_err, z_m1_ack, z_m1_err, z_s_cyc, z_s_stb, z_s_we;
  logic [AW-1:0] z_s_adr;
  logic [3:0]    z_s_sel;

  int n_vec = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  wb_arbiter2 #(.ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_mosi(m0_mosi), .m0_sel(m0_sel), .m0_miso(m0_miso), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_mosi(m1_mosi), .m1_sel(m1_sel), .m1_miso(m1_miso), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_mosi(s_mosi), .s_sel(s_sel),
    .s_miso(s_miso), .s_ack(s_ack), .s_err(s_err)
  );

  wb_arbiter2 #(.ADDR_WIDTH(AW), .TIMEOUT(0)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_mosi(m0_mosi), .m0_sel(m0_sel), .m0_miso(z_m0_miso), .m0_ack(z_m0_ack), .m0_err(z_m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_mosi(m1_mosi), .m1_sel(m1_sel), .m1_miso(z_m1_miso), .m1_ack(z_m1_ack), .m1_err(z_m1_err),
    .s_cyc(z_s_cyc), .s_stb(z_s_stb), .s_we(z_s_we), .s_adr(z_s_adr), .s_mosi(z_s_mosi), .s_sel(z_s_sel),
    .s_miso(s_miso), .s_ack(s_ack), .s_err(s_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst = 1'b0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_mosi = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_mosi = '0; m1_sel = '0;
    s_miso = '0; s_ack = 0; s_err = 0;

    // ---- reset: outputs quiet even with live requests and a slave response ----
    tick(); tick();
    m0_cyc = 1; m0_stb = 1; s_ack = 1; s_miso = 32'h1234_5678;
    #1;
    chk("rst_s_cyc",   s_cyc,   0);
    chk("rst_s_stb",   s_stb,   0);
    chk("rst_s_adr",   s_adr,   0);
    chk("rst_m0_ack",  m0_ack,  0);
    chk("rst_m0_miso", m0_miso, 0);
    chk("rst_m1_err",  m1_err,  0);
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0; s_miso = '0;

    // ---- both masters request from IDLE: m0 first, then m1 on hand-over ----
    sys_rst = 1;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h100; m0_mosi = 32'hAAAA_0000; m0_sel = 4'hF;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h200; m1_mosi = 32'hBBBB_0000; m1_sel = 4'h3;
    #1;
    chk("idle_s_cyc", s_cyc, 0);
    tick();
    chk("g0_s_cyc",  s_cyc,  1);
    chk("g0_s_stb",  s_stb,  1);
    chk("g0_s_adr",  s_adr,  32'h100);
    chk("g0_s_mosi", s_mosi, 32'hAAAA_0000);
    chk("g0_s_we",   s_we,   1);
    chk("g0_s_sel",  s_sel,  4'hF);
    s_ack = 1;
    #1;
    chk("g0_m0_ack", m0_ack, 1);
    chk("g0_m1_ack", m1_ack, 0);
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1;
    chk("g0_drop_s_cyc", s_cyc, 0);
    tick();
    chk("g1_s_adr", s_adr, 32'h200);
    chk("g1_s_sel", s_sel, 4'h3);
    chk("g1_s_cyc", s_cyc, 1);

    // ---- m1 read of 0x10 returns 0xDEADBEEF ----
    m1_adr = 32'h10; s_miso = 32'hDEAD_BEEF; s_ack = 1;
    #1;
    chk("rd_s_adr",   s_adr,   32'h10);
    chk("rd_m1_miso", m1_miso, 32'hDEAD_BEEF);
    chk("rd_m1_ack",  m1_ack,  1);
    chk("rd_m0_ack",  m0_ack,  0);
    chk("rd_m0_miso", m0_miso, 0);
    tick();
    m1_cyc = 0; m1_stb = 0; s_ack = 0; s_miso = '0;
    tick();
    chk("back_idle_s_cyc", s_cyc, 0);
    chk("back_idle_s_adr", s_adr, 0);

    // ---- continuous requests from both: grants alternate 0,1,0,1 ----
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("alt%0d_s_adr", k), s_adr, (k % 2 == 1) ? 32'hB0 : 32'hA0);
      chk($sformatf("alt%0d_s_cyc", k), s_cyc, 1);
      s_ack = 1;
      #1;
      chk($sformatf("alt%0d_m0_ack", k), m0_ack, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d_m1_ack", k), m1_ack, (k % 2 == 1) ? 1 : 0);
      tick();
      s_ack = 0;
      if (k == 3) begin
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      end else if (k % 2 == 0) begin
        m0_cyc = 0; m0_stb = 0;
      end else begin
        m1_cyc = 0; m1_stb = 0;
      end
      tick();
      if (k < 3) begin
        if (k % 2 == 0) begin m0_cyc = 1; m0_stb = 1; end
        else            begin m1_cyc = 1; m1_stb = 1; end
      end
    end
    #1;
    chk("both_drop_s_cyc", s_cyc, 0);

    // ---- timeout: silent slave, err on the 4th strobe cycle ----
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("to_c%0d_m0_err", c), m0_err, (c == 4) ? 1 : 0);
      chk($sformatf("to_c%0d_s_stb", c), s_stb, 1);
      chk($sformatf("to0_c%0d_m0_err", c), z_m0_err, 0);
      tick();
    end
    chk("to_after_s_stb",  s_stb,   0);
    chk("to_after_m0_err", m0_err,  0);
    chk("to_after_s_cyc",  s_cyc,   1);
    chk("to0_after_s_stb", z_s_stb, 1);
    tick();
    chk("to_hold_s_stb", s_stb, 0);
    m0_stb = 0;
    tick();
    m0_stb = 1;
    #1;
    chk("to_release_s_stb",  s_stb,  1);
    chk("to_release_m0_err", m0_err, 0);

    // ---- ack in the final cycle beats the timeout ----
    tick(); tick(); tick();
    s_ack = 1;
    #1;
    chk("race_m0_ack", m0_ack, 1);
    chk("race_m0_err", m0_err, 0);
    tick();
    s_ack = 0;
    #1;
    chk("race_after_s_stb",  s_stb,  1);
    chk("race_after_m0_err", m0_err, 0);

    // ---- reset in the middle of a GRANT1 cycle ----
    m0_cyc = 0; m0_stb = 0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h400;
    tick();
    chk("pre_rst_s_adr", s_adr, 32'h400);
    chk("pre_rst_s_cyc", s_cyc, 1);
    sys_rst = 0; s_ack = 1;
    #1;
    chk("in_rst_m1_ack", m1_ack, 0);
    chk("in_rst_s_cyc",  s_cyc,  0);
    tick();
    sys_rst = 1;
    #1;
    chk("post_rst_s_cyc",  s_cyc,  0);
    chk("post_rst_m1_ack", m1_ack, 0);
    s_ack = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h500;
    tick();
    chk("post_rst_tie_s_adr", s_adr,  32'h500);
    chk("post_rst_m1_miso",   m1_miso, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
